// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for reg_file_sb.
//   SP_IDX_DEF/SP_INIT_DEF, GP_IDX_DEF/GP_INIT_DEF : default pointer registers and reset values
//   slice_lo(i, w)  : base bit of packed lane i of width w
//   reset_val(idx)  : reset contents of register idx
package rf_pkg;
   localparam int          SP_IDX_DEF  = 2;
   localparam logic [31:0] SP_INIT_DEF = 32'hF00;
   localparam int          GP_IDX_DEF  = 3;
   localparam logic [31:0] GP_INIT_DEF = 32'h100;

   function automatic int slice_lo(input int i, input int w);
      return i * w;
   endfunction

   function automatic logic [31:0] reset_val(input int idx,
                                             input int sp_idx = SP_IDX_DEF,
                                             input logic [31:0] sp_init = SP_INIT_DEF,
                                             input int gp_idx = GP_IDX_DEF,
                                             input logic [31:0] gp_init = GP_INIT_DEF);
      return (idx == sp_idx) ? sp_init : (idx == gp_idx) ? gp_init : 32'h0;
   endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for RAW hazard detection.
//   CLK, RSTn (sync, active-low) ; ISS_V/ISS_A set a bit ; WE/WA clear a bit
//   RA -> RBUSY per read port ; BUSY_VEC exposes the whole array
module rf_scoreboard import rf_pkg::*; #(
   parameter int MDEPTH = 32,
   parameter int AWIDTH = $clog2(MDEPTH),
   parameter int NRD    = 2,
   parameter int NWR    = 2
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic [NRD*AWIDTH-1:0] RA,
   input  logic [NWR-1:0]        WE,
   input  logic [NWR*AWIDTH-1:0] WA,
   input  logic                  ISS_V,
   input  logic [AWIDTH-1:0]     ISS_A,
   output logic [NRD-1:0]        RBUSY,
   output logic [MDEPTH-1:0]     BUSY_VEC
);
   logic [MDEPTH-1:0] r_busy;
   logic [MDEPTH-1:0] w_set;
   logic [MDEPTH-1:0] w_clr;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (ISS_V) w_set[ISS_A] = 1'b1;
      for (int j = 0; j < NWR; j++)
         if (WE[j]) w_clr[WA[slice_lo(j, AWIDTH) +: AWIDTH]] = 1'b1;
   end

   // set beats clear: a fresh producer supersedes the retiring one; bit 0 never busy
   always_ff @(posedge CLK)
      if (!RSTn) r_busy <= '0;
      else       r_busy <= (w_set | (r_busy & ~w_clr)) & ~MDEPTH'(1);

   // a writeback this cycle already satisfies the hazard through the bypass
   for (genvar i = 0; i < NRD; i++) begin : g_rb
      logic [AWIDTH-1:0] w_ra;
      assign w_ra     = RA[slice_lo(i, AWIDTH) +: AWIDTH];
      assign RBUSY[i] = r_busy[w_ra] && !w_clr[w_ra];
   end

   assign BUSY_VEC = r_busy;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write bypass and busy-bit scoreboard.
//   CLK, RSTn (sync, active-low)
//   RA/RD/RBUSY : NRD combinational read ports
//   WE/WA/WD    : NWR prioritised write ports (highest port wins)
//   ISS_V/ISS_A : issue marks destination busy ; BUSY_VEC : full scoreboard
module reg_file_sb import rf_pkg::*; #(
   parameter int          DWIDTH  = 32,
   parameter int          MDEPTH  = 32,
   parameter int          AWIDTH  = $clog2(MDEPTH),
   parameter int          NRD     = 2,
   parameter int          NWR     = 2,
   parameter int          SP_IDX  = SP_IDX_DEF,
   parameter logic [31:0] SP_INIT = SP_INIT_DEF,
   parameter int          GP_IDX  = GP_IDX_DEF,
   parameter logic [31:0] GP_INIT = GP_INIT_DEF
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic [NRD*AWIDTH-1:0] RA,
   output logic [NRD*DWIDTH-1:0] RD,
   output logic [NRD-1:0]        RBUSY,
   input  logic [NWR-1:0]        WE,
   input  logic [NWR*AWIDTH-1:0] WA,
   input  logic [NWR*DWIDTH-1:0] WD,
   input  logic                  ISS_V,
   input  logic [AWIDTH-1:0]     ISS_A,
   output logic [MDEPTH-1:0]     BUSY_VEC
);
   logic [DWIDTH-1:0] r_rf [MDEPTH];

   // ascending port order lets the last NBA (highest port) win on collisions
   always_ff @(posedge CLK)
      if (!RSTn)
         for (int r = 0; r < MDEPTH; r++)
            r_rf[r] <= DWIDTH'(reset_val(r, SP_IDX, SP_INIT, GP_IDX, GP_INIT));
      else
         for (int j = 0; j < NWR; j++)
            if (WE[j] && WA[slice_lo(j, AWIDTH) +: AWIDTH] != '0)
               r_rf[WA[slice_lo(j, AWIDTH) +: AWIDTH]] <= WD[slice_lo(j, DWIDTH) +: DWIDTH];

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AWIDTH-1:0] w_ra;
      logic [DWIDTH-1:0] w_rd;
      assign w_ra = RA[slice_lo(i, AWIDTH) +: AWIDTH];
      always_comb begin
         w_rd = r_rf[w_ra];
         for (int j = 0; j < NWR; j++)
            if (WE[j] && WA[slice_lo(j, AWIDTH) +: AWIDTH] == w_ra)
               w_rd = WD[slice_lo(j, DWIDTH) +: DWIDTH];
         if (w_ra == '0) w_rd = '0;
      end
      assign RD[slice_lo(i, DWIDTH) +: DWIDTH] = w_rd;
   end

   rf_scoreboard #(
      .MDEPTH(MDEPTH), .AWIDTH(AWIDTH), .NRD(NRD), .NWR(NWR)
   ) u_sb (
      .CLK(CLK), .RSTn(RSTn), .RA(RA), .WE(WE), .WA(WA),
      .ISS_V(ISS_V), .ISS_A(ISS_A), .RBUSY(RBUSY), .BUSY_VEC(BUSY_VEC)
   );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb.
module tb_reg_file_sb;
   logic        CLK = 1'b0;
   logic        RSTn;
   logic [9:0]  RA;
   logic [63:0] RD;
   logic [1:0]  RBUSY;
   logic [1:0]  WE;
   logic [9:0]  WA;
   logic [63:0] WD;
   logic        ISS_V;
   logic [4:0]  ISS_A;
   logic [31:0] BUSY_VEC;
   int total = 0;
   int bad = 0;

   reg_file_sb dut (
      .CLK(CLK), .RSTn(RSTn), .RA(RA), .RD(RD), .RBUSY(RBUSY),
      .WE(WE), .WA(WA), .WD(WD), .ISS_V(ISS_V), .ISS_A(ISS_A), .BUSY_VEC(BUSY_VEC)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      WE = 2'b00; WA = '0; WD = '0; ISS_V = 1'b0; ISS_A = '0;
   endtask

   initial begin
      RSTn = 1'b0; RA = '0; idle();
      @(negedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;
      #1;
      chk("rst_busy_vec", BUSY_VEC, 32'h0);
      chk("rst_rbusy", {30'h0, RBUSY}, 32'h0);
      for (int r = 0; r < 32; r++) begin
         RA[4:0] = 5'(r);
         RA[9:5] = 5'(31 - r);
         #1;
         chk($sformatf("rst_rd0_r%0d", r), RD[31:0],
             (r == 2) ? 32'hF00 : (r == 3) ? 32'h100 : 32'h0);
         chk($sformatf("rst_rd1_r%0d", 31 - r), RD[63:32],
             (31 - r == 2) ? 32'hF00 : (31 - r == 3) ? 32'h100 : 32'h0);
      end
      // dual-port collision on reg 5: port 1 wins
      @(negedge CLK);
      WE = 2'b11; WA = {5'd5, 5'd5}; WD = {32'h5555, 32'hAAAA}; RA = {5'd0, 5'd5};
      #1;
      chk("coll_bypass", RD[31:0], 32'h5555);
      chk("coll_rd1_x0", RD[63:32], 32'h0);
      @(negedge CLK);
      idle();
      #1;
      chk("coll_stored", RD[31:0], 32'h5555);
      // bypass over stored value
      WE = 2'b01; WA = {5'd0, 5'd7}; WD = {32'h0, 32'h11};
      @(negedge CLK);
      WE = 2'b01; WA = {5'd0, 5'd7}; WD = {32'h0, 32'h22}; RA = {5'd7, 5'd7};
      #1;
      chk("byp_rd0", RD[31:0], 32'h22);
      chk("byp_rd1", RD[63:32], 32'h22);
      @(negedge CLK);
      idle();
      #1;
      chk("byp_stored", RD[31:0], 32'h22);
      // write to x0 is ignored and never bypassed
      WE = 2'b01; WA = {5'd0, 5'd0}; WD = {32'h0, 32'hFFFF}; RA = {5'd7, 5'd0};
      #1;
      chk("x0_bypass", RD[31:0], 32'h0);
      @(negedge CLK);
      idle();
      #1;
      chk("x0_stored", RD[31:0], 32'h0);
      chk("x0_busy", BUSY_VEC, 32'h0);
      // scoreboard set then writeback clear
      ISS_V = 1'b1; ISS_A = 5'd9; RA = {5'd9, 5'd9};
      #1;
      chk("iss_not_yet", {30'h0, RBUSY}, 32'h0);
      @(negedge CLK);
      idle();
      #1;
      chk("iss_rbusy", {30'h0, RBUSY}, 32'h3);
      chk("iss_vec", BUSY_VEC, 32'h0000_0200);
      WE = 2'b10; WA = {5'd9, 5'd0}; WD = {32'h33, 32'h0};
      #1;
      chk("wb_rbusy_clr", {30'h0, RBUSY}, 32'h0);
      chk("wb_bypass", RD[31:0], 32'h33);
      chk("wb_vec_still", BUSY_VEC, 32'h0000_0200);
      @(negedge CLK);
      idle();
      #1;
      chk("wb_vec_clr", BUSY_VEC, 32'h0);
      chk("wb_stored", RD[63:32], 32'h33);
      // set wins over simultaneous writeback; issue to x0 ignored
      ISS_V = 1'b1; ISS_A = 5'd9;
      @(negedge CLK);
      ISS_V = 1'b1; ISS_A = 5'd9; WE = 2'b01; WA = {5'd0, 5'd9}; WD = {32'h0, 32'h44};
      @(negedge CLK);
      idle();
      ISS_V = 1'b1; ISS_A = 5'd0;
      #1;
      chk("setwin_vec", BUSY_VEC, 32'h0000_0200);
      chk("setwin_rbusy", {30'h0, RBUSY}, 32'h3);
      chk("setwin_data", RD[31:0], 32'h44);
      @(negedge CLK);
      idle();
      #1;
      chk("iss_x0_vec", BUSY_VEC, 32'h0000_0200);
      // reset mid-flight discards busy bits and writes
      ISS_V = 1'b1; ISS_A = 5'd4; WE = 2'b10; WA = {5'd2, 5'd0}; WD = {32'hABC, 32'h0};
      @(negedge CLK);
      idle();
      RA = {5'd4, 5'd2};
      #1;
      chk("pre_rst_vec", BUSY_VEC, 32'h0000_0210);
      chk("pre_rst_sp", RD[31:0], 32'hABC);
      chk("pre_rst_rbusy4", {31'h0, RBUSY[1]}, 32'h1);
      RSTn = 1'b0; WE = 2'b01; WA = {5'd0, 5'd4}; WD = {32'h0, 32'h77};
      @(negedge CLK);
      RSTn = 1'b1;
      idle();
      #1;
      chk("mid_rst_r4", RD[63:32], 32'h0);
      chk("mid_rst_sp", RD[31:0], 32'hF00);
      chk("mid_rst_vec", BUSY_VEC, 32'h0);
      chk("mid_rst_rbusy", {30'h0, RBUSY}, 32'h0);
      RA = {5'd9, 5'd3};
      #1;
      chk("mid_rst_gp", RD[31:0], 32'h100);
      chk("mid_rst_r9", RD[63:32], 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port register file for the pipelined core, succeeding the single-write, negedge-clocked file. Provides NRD asynchronous read ports with same-cycle write-to-read bypass, NWR prioritised synchronous write ports, and a per-register scoreboard (busy bits) that the decode stage uses to detect RAW hazards. Sits between decode (reads, issue) and writeback (writes, busy clear).

## Interface
- DWIDTH, 32, data width
- MDEPTH, 32, number of registers (power of two, ≥4)
- AWIDTH, $clog2(MDEPTH), register address width
- NRD, 2, read ports
- NWR, 2, write ports
- SP_IDX, 2, index of stack-pointer register; SP_INIT, 32'hF00, its reset value
- GP_IDX, 3, index of global-pointer register; GP_INIT, 32'h100, its reset value

- CLK  in  1  clock, all state updates on rising edge
- RSTn  in  1  reset, synchronous, active-low
- RA  in  NRD*AWIDTH  read addresses, port i at [i*AWIDTH +: AWIDTH]
- RD  out  NRD*DWIDTH  read data, port i packed likewise
- RBUSY  out  NRD  port i source register has a pending producer
- WE  in  NWR  write enables
- WA  in  NWR*AWIDTH  write addresses
- WD  in  NWR*DWIDTH  write data
- ISS_V  in  1  issue valid: instruction with destination ISS_A enters pipeline
- ISS_A  in  AWIDTH  destination register of issued instruction
- BUSY_VEC  out  MDEPTH  full scoreboard, bit r = register r busy

## Operation
- Register 0: reads always 0; writes and issues to address 0 ignored; busy[0] always 0.
- Write: on rising edge, for each port j with WE[j] and WA[j]≠0, RF[WA[j]] ← WD[j]. Same address on multiple ports: highest j wins.
- Read (combinational): RD[i] = 0 if RA[i]=0; else WD[j] of the highest j with WE[j] && WA[j]==RA[i] (bypass); else RF[RA[i]].
- Scoreboard per register r≠0, next state on rising edge:
  - set if ISS_V && ISS_A==r;
  - else clear if any WE[j] && WA[j]==r;
  - else hold. Simultaneous issue and write to r: set wins (new producer supersedes writeback).
- Write to a non-busy register allowed; busy unaffected except clear.
- RBUSY[i] = busy[RA[i]] && !(any WE[j] && WA[j]==RA[i]) (a writeback in the current cycle satisfies the hazard via bypass).
- Reset (RSTn=0 at rising edge) has priority over all writes/issues: RF[SP_IDX]←SP_INIT, RF[GP_IDX]←GP_INIT, all others 0, all busy 0.

## Timing
- Read latency 0 (combinational from RA, WE, WA, WD, state).
- Write visible in RF the edge after WE; visible on RD the same cycle via bypass.
- Issue sets busy visible the cycle after ISS_V; RBUSY for that register goes high that following cycle.
- After reset deassert: RD of SP_IDX = 32'hF00, GP_IDX = 32'h100, others 0; RBUSY=0; BUSY_VEC=0.
- Reset mid-operation: pending busy bits and in-flight writes in the reset cycle are discarded.
- No X on outputs after first reset edge; RA with out-of-range addresses impossible (MDEPTH = 2^AWIDTH).

## Structure
- Package rf_pkg: localparams for default SP/GP index and init values, function for packed-slice extraction, reset-value function reset_val(idx).
- Sub-module rf_scoreboard: busy-bit array with set/clear priority and RBUSY generation; the data array, write-priority and bypass muxes stay in reg_file_sb.

## Test plan
- Reset: RSTn=0 one edge, then read all 32 regs -> reg2=0xF00, reg3=0x100, rest 0, BUSY_VEC=0.
- Dual write collision: WE=2'b11, WA0=WA1=5, WD0=0xAAAA, WD1=0x5555 -> same cycle RD(RA=5)=0x5555; next cycle RF[5]=0x5555.
- Bypass: RF[7]=0x11, WE0 WA0=7 WD0=0x22, RA0=7 -> RD0=0x22 same cycle; x0 write 0xFFFF -> RD(0)=0.
- Scoreboard: ISS_V ISS_A=9 -> next cycle RBUSY(RA=9)=1; WE WA=9 WD=0x33 -> RBUSY=0 that cycle, busy[9]=0 next.
- Set-wins: busy[9]=1, same cycle ISS_V ISS_A=9 and WE WA=9 -> busy[9] stays 1, RF[9] updated.
- Reset mid-flight: busy[4]=1, WE WA=4 WD=0x77 with RSTn=0 -> RF[4]=0, busy[4]=0.
